// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package rr_arbiter_8_pkg;

  localparam int N_REQ            = 8;
  localparam int CODE_W           = 3;
  localparam int HOLD_MAX_DEFAULT = 16;
  localparam int CNT_W_DEFAULT    = 5;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

endpackage : rr_arbiter_8_pkg

// File: rtl/rr_arbiter_8_onehot_to_bin_8.sv
// One-hot to binary encoder for the arbiter grant vector.
// Zero or multi-hot inputs encode to 0 so the code is never X.
module onehot_to_bin_8
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0]  onehot,
  output logic [CODE_W-1:0] code
);

  // Map each legal one-hot pattern to its index; everything else gives 0.
  always_comb begin
    case (onehot)
      8'b0000_0001: code = 3'd0;
      8'b0000_0010: code = 3'd1;
      8'b0000_0100: code = 3'd2;
      8'b0000_1000: code = 3'd3;
      8'b0001_0000: code = 3'd4;
      8'b0010_0000: code = 3'd5;
      8'b0100_0000: code = 3'd6;
      8'b1000_0000: code = 3'd7;
      default:      code = 3'd0;
    endcase
  end

endmodule : onehot_to_bin_8

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant, binary
// grant code, hold timeout and a mandatory idle cycle between grants.
// The owner-done input is named owner_release because "release" is a
// reserved word in SystemVerilog.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
)
(
  input  logic              clock,
  input  logic              clear,
  input  logic [N_REQ-1:0]  req,
  input  logic              owner_release,
  output logic [N_REQ-1:0]  grant,
  output logic [CODE_W-1:0] grant_code,
  output logic              grant_valid,
  output logic              timeout
);

  localparam logic             LIMIT_EN  = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? {CNT_W{1'b0}}
                                                           : CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [CODE_W-1:0]   grant_code_q, grant_code_d;
  logic                grant_valid_q, grant_valid_d;
  logic                timeout_q, timeout_d;

  logic [N_REQ-1:0]    req_rot_s;
  logic [N_REQ-1:0]    pick_rot_s;
  logic [N_REQ-1:0]    pick_oh_s;
  logic                owner_req_s;
  logic                at_limit_s;
  logic                rel_s;

  // Circular priority pick: rotate so ptr is bit 0, isolate lowest set bit, rotate back.
  always_comb begin
    req_rot_s = {N_REQ{1'b0}};
    pick_oh_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      req_rot_s[i] = req[CODE_W'(i) + ptr_q];
    end
    pick_rot_s = req_rot_s & (~req_rot_s + 8'd1);
    for (int i = 0; i < N_REQ; i++) begin
      pick_oh_s[CODE_W'(i) + ptr_q] = pick_rot_s[i];
    end
  end

  // Release condition for the current owner: done pulse, request dropped, or hold limit.
  always_comb begin
    owner_req_s = req[grant_code_q];
    at_limit_s  = LIMIT_EN && (hold_cnt_q == HOLD_LAST);
    rel_s       = owner_release | ~owner_req_s | at_limit_s;
  end

  // Next-state logic: IDLE grants on any request, GRANTED returns to IDLE on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANTED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANTED: begin
        if (rel_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: next grant, pointer rotation, hold counter, timeout pulse.
  always_comb begin
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = {CNT_W{1'b0}};
        if (|req) begin
          grant_d = pick_oh_s;
        end else begin
          grant_d = {N_REQ{1'b0}};
        end
      end
      ST_GRANTED: begin
        if (rel_s) begin
          grant_d    = {N_REQ{1'b0}};
          ptr_d      = grant_code_q + 3'd1;
          hold_cnt_d = {CNT_W{1'b0}};
          // Only flag a forced release when nothing else would have ended the grant.
          timeout_d  = ~owner_release & owner_req_s;
        end else if (hold_cnt_q != CNT_SAT) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1'b1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
      end
      default: begin
        grant_d    = {N_REQ{1'b0}};
        ptr_d      = 3'd0;
        hold_cnt_d = {CNT_W{1'b0}};
      end
    endcase
    grant_valid_d = |grant_d;
  end

  // Binary code of the next grant, registered alongside it.
  onehot_to_bin_8 u_enc (
    .onehot (grant_d),
    .code   (grant_code_d)
  );

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 3'd0;
      hold_cnt_q    <= {CNT_W{1'b0}};
      grant_q       <= {N_REQ{1'b0}};
      grant_code_q  <= 3'd0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_code_q  <= grant_code_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_code  = grant_code_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule : rr_arbiter_8
